// File: rtl/scalar_logical_pipe_if.sv
// Issue/result bus of the pipelined scalar logical unit.
//   master : issue side (register read / issue logic) drives i_*, sees o_*
//   slave  : the pipe itself, consumes i_*, drives o_*
// i_hold freezes the whole pipe; i_valid/i_instr/i_j/i_k/i_tag/i_sj/i_sk/i_si
// describe one operation; o_valid/o_result/o_tag/o_illegal report completion.
interface scalar_logical_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 3
);
  logic             i_hold;
  logic             i_valid;
  logic [6:0]       i_instr;
  logic [2:0]       i_j;
  logic [2:0]       i_k;
  logic [TAG_W-1:0] i_tag;
  logic [WIDTH-1:0] i_sj;
  logic [WIDTH-1:0] i_sk;
  logic [WIDTH-1:0] i_si;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic [TAG_W-1:0] o_tag;
  logic             o_illegal;

  modport master (
    output i_hold, i_valid, i_instr, i_j, i_k, i_tag, i_sj, i_sk, i_si,
    input  o_valid, o_result, o_tag, o_illegal
  );

  modport slave (
    input  i_hold, i_valid, i_instr, i_j, i_k, i_tag, i_sj, i_sk, i_si,
    output o_valid, o_result, o_tag, o_illegal
  );
endinterface

// File: rtl/scalar_logical_pipe.sv
// Pipelined scalar logical unit: masks (042/043), boolean ops (044-047, 051),
// merge (050), population count / parity (026) and leading-zero count (027).
// Result is computed combinationally in front of stage 1, then delayed through
// STAGES registers together with valid, illegal and tag.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, beats hold and issue
//   bus  - slave side of scalar_logical_pipe_if (issue in, result out)
module scalar_logical_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 3
) (
  input logic                clk,
  input logic                rst,
  scalar_logical_pipe_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic             vld;
    logic             ill;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
  } stage_t;

  logic [WIDTH-1:0] fj, fk, res0;
  logic [5:0]       jk;
  logic [CW-1:0]    pop, lzc;
  logic             legal;
  stage_t           pipe [1:STAGES];

  // j==0 reads as zero, k==0 reads as the sign-bit constant
  assign fj = (bus.i_j == 3'd0) ? '0   : bus.i_sj;
  assign fk = (bus.i_k == 3'd0) ? SIGN : bus.i_sk;
  assign jk = {bus.i_j, bus.i_k};

  // Population count and leading-zero count; the last set bit seen while
  // scanning upward is the most significant one, so it decides lzc.
  always_comb begin
    pop = '0;
    lzc = CW'(WIDTH);
    for (int b = 0; b < WIDTH; b++) begin
      pop = pop + CW'(fj[b]);
      if (fj[b]) lzc = CW'(WIDTH - 1 - b);
    end
  end

  // Shifts of jk >= WIDTH fall off the end, giving 0 for 042 and all ones
  // (min(jk,WIDTH) ones) for 043 without extra clamping.
  always_comb begin
    res0  = '0;
    legal = 1'b1;
    case (bus.i_instr)
      7'o042: res0 = ONES >> jk;
      7'o043: res0 = ~(ONES >> jk);
      7'o044: res0 = fj & fk;
      7'o045: res0 = fj & ~fk;
      7'o046: res0 = fj ^ fk;
      7'o047: res0 = ~(fj ^ fk);
      7'o050: res0 = (fj & fk) | (bus.i_si & ~fk);
      7'o051: res0 = fj | fk;
      7'o026: begin
        if (bus.i_k == 3'd0)      res0 = {{(WIDTH-CW){1'b0}}, pop};
        else if (bus.i_k == 3'd1) res0 = {{(WIDTH-1){1'b0}}, ^fj};
        else                      legal = 1'b0;
      end
      7'o027: begin
        if (bus.i_k == 3'd0) res0 = {{(WIDTH-CW){1'b0}}, lzc};
        else                 legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // Whole pipe advances together or not at all; an issue during hold is
  // simply never sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= STAGES; s++) pipe[s] <= '0;
    end else if (!bus.i_hold) begin
      pipe[1].vld <= bus.i_valid & legal;
      pipe[1].ill <= bus.i_valid & ~legal;
      pipe[1].tag <= bus.i_tag;
      pipe[1].res <= res0;
      for (int s = 2; s <= STAGES; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign bus.o_valid   = pipe[STAGES].vld;
  assign bus.o_illegal = pipe[STAGES].ill;
  assign bus.o_tag     = pipe[STAGES].tag;
  assign bus.o_result  = pipe[STAGES].res;
endmodule

// File: tb/tb_scalar_logical_pipe.sv
module tb_scalar_logical_pipe;
  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 3;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  scalar_logical_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) ifc ();

  scalar_logical_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    bit               ill;
    int               rem;
  } ent_t;

  ent_t             q[$];
  bit               ev, ei, known;
  logic [63:0]      eres;
  logic [TAG_W-1:0] etag;

  // Reference: each operation is defined straight from the bit-level rules.
  function automatic void ref_op(input logic [6:0] ins, input logic [2:0] j, k,
                                 input logic [63:0] sj, sk, si,
                                 output logic [63:0] r, output bit legal);
    logic [63:0] fj, fk;
    int jk;
    fj = (j == 0) ? 64'd0 : sj;
    fk = (k == 0) ? 64'h8000_0000_0000_0000 : sk;
    jk = int'(j) * 8 + int'(k);
    r = 64'd0;
    legal = 1'b1;
    case (ins)
      7'o042: for (int b = 0; b < 64; b++) r[b] = (b < 64 - jk);
      7'o043: for (int b = 0; b < 64; b++) r[b] = (b >= 64 - jk);
      7'o044: r = fj & fk;
      7'o045: r = fj & ~fk;
      7'o046: r = fj ^ fk;
      7'o047: r = ~(fj ^ fk);
      7'o050: for (int b = 0; b < 64; b++) r[b] = fk[b] ? fj[b] : si[b];
      7'o051: r = fj | fk;
      7'o026: begin
        if (k == 0)      r = 64'($countones(fj));
        else if (k == 1) r = 64'($countones(fj) % 2);
        else             legal = 1'b0;
      end
      7'o027: begin
        if (k == 0) begin
          r = 64'd64;
          for (int b = 63; b >= 0; b--) if (fj[b]) begin r = 64'(63 - b); break; end
        end else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the inputs presented at the edge, advance the model,
  // then compare DUT outputs just after the edge.
  task automatic step();
    bit r, h, v, legal;
    logic [63:0] res;
    ent_t e;
    r = rst; h = ifc.i_hold; v = ifc.i_valid;
    ref_op(ifc.i_instr, ifc.i_j, ifc.i_k, ifc.i_sj, ifc.i_sk, ifc.i_si, res, legal);
    e.res = res; e.tag = ifc.i_tag; e.ill = !legal; e.rem = STAGES;
    @(posedge clk); #1;
    if (r) begin
      q.delete();
      ev = 0; ei = 0; eres = '0; etag = '0; known = 1;
    end else if (!h) begin
      if (v) q.push_back(e);
      ev = 0; ei = 0; known = 0;
      for (int i = 0; i < q.size(); i++) q[i].rem--;
      if (q.size() > 0 && q[0].rem == 0) begin
        e = q.pop_front();
        if (e.ill) ei = 1;
        else begin ev = 1; eres = e.res; etag = e.tag; end
      end
    end
    chk("o_valid", 64'(ifc.o_valid), 64'(ev));
    chk("o_illegal", 64'(ifc.o_illegal), 64'(ei));
    if (ev || known) begin
      chk("o_result", ifc.o_result, eres);
      chk("o_tag", 64'(ifc.o_tag), 64'(etag));
    end
  endtask

  task automatic drive(input logic [6:0] ins, input logic [2:0] j, k,
                       input logic [63:0] sj, sk, si, input logic [TAG_W-1:0] tag);
    ifc.i_valid = 1'b1; ifc.i_instr = ins; ifc.i_j = j; ifc.i_k = k;
    ifc.i_sj = sj; ifc.i_sk = sk; ifc.i_si = si; ifc.i_tag = tag;
  endtask

  task automatic issue(input logic [6:0] ins, input logic [2:0] j, k,
                       input logic [63:0] sj, sk, si, input logic [TAG_W-1:0] tag);
    drive(ins, j, k, sj, sk, si, tag);
    step();
    ifc.i_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [6:0] ins, input logic [2:0] j, k,
                          input logic [63:0] sj, sk, si, input logic [63:0] exp);
    issue(ins, j, k, sj, sk, si, 3'd2);
    repeat (STAGES - 1) step();
    chk({name, "_valid"}, 64'(ifc.o_valid), 64'd1);
    chk({name, "_res"}, ifc.o_result, exp);
  endtask

  logic [6:0] ops [12] = '{7'o026, 7'o027, 7'o030, 7'o042, 7'o043, 7'o044,
                           7'o045, 7'o046, 7'o047, 7'o050, 7'o051, 7'o077};

  initial begin
    rst = 1'b1;
    ifc.i_hold = 0; ifc.i_valid = 0; ifc.i_instr = 0; ifc.i_j = 0; ifc.i_k = 0;
    ifc.i_tag = 0; ifc.i_sj = 0; ifc.i_sk = 0; ifc.i_si = 0;
    ev = 0; ei = 0; known = 0; eres = 0; etag = 0;

    // Reset, then latency of a single AND
    step(); step();
    chk("rst_result", ifc.o_result, 64'd0);
    rst = 1'b0;
    issue(7'o044, 3'd1, 3'd1, 64'hFF00, 64'h0FF0, 64'd0, 3'd5);
    chk("lat_early", 64'(ifc.o_valid), 64'd0);
    step();
    chk("lat_valid", 64'(ifc.o_valid), 64'd1);
    chk("lat_res", ifc.o_result, 64'h0F00);
    chk("lat_tag", 64'(ifc.o_tag), 64'd5);

    // Masks, j/k special cases, merge and counts
    directed("m042_4", 7'o042, 3'd0, 3'd4, 64'd0, 64'd0, 64'd0, 64'h0FFF_FFFF_FFFF_FFFF);
    directed("m043_8", 7'o043, 3'd1, 3'd0, 64'd0, 64'd0, 64'd0, 64'hFF00_0000_0000_0000);
    directed("m043_0", 7'o043, 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    directed("or_k0",  7'o051, 3'd1, 3'd0, 64'd1, 64'd0, 64'd0, 64'h8000_0000_0000_0001);
    directed("and_j0", 7'o044, 3'd0, 3'd3, 64'hFFFF, 64'hFFFF, 64'd0, 64'd0);
    directed("merge",  7'o050, 3'd1, 3'd1, 64'h5555_5555_5555_5555,
             64'h0000_0000_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_5555_5555);
    directed("popcnt", 7'o026, 3'd1, 3'd0, 64'hF0F0, 64'd0, 64'd0, 64'd8);
    directed("parity", 7'o026, 3'd1, 3'd1, 64'h7, 64'd0, 64'd0, 64'd1);
    directed("lzc_0",  7'o027, 3'd1, 3'd0, 64'd0, 64'd0, 64'd0, 64'd64);
    directed("lzc_1",  7'o027, 3'd1, 3'd0, 64'd1, 64'd0, 64'd0, 64'd63);

    // Eight back-to-back ops with a 3-cycle hold in the middle
    for (int n = 0; n < 8; n++) begin
      if (n == 4) begin
        ifc.i_valid = 0; ifc.i_hold = 1;
        repeat (3) step();
        ifc.i_hold = 0;
      end
      drive(7'o046, 3'd1, 3'd1, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, TAG_W'(n));
      step();
    end
    ifc.i_valid = 0;
    repeat (STAGES + 1) step();

    // Unsupported opcode followed by a legal XOR
    issue(7'o030, 3'd1, 3'd1, 64'd0, 64'd0, 64'd0, 3'd6);
    issue(7'o046, 3'd1, 3'd1, 64'hF0, 64'h3C, 64'd0, 3'd1);
    repeat (STAGES - 2) step();
    chk("ill_pulse", 64'(ifc.o_illegal), 64'd1);
    chk("ill_novalid", 64'(ifc.o_valid), 64'd0);
    step();
    chk("ill_next_valid", 64'(ifc.o_valid), 64'd1);
    chk("ill_next_res", ifc.o_result, 64'hCC);
    chk("ill_next_ill", 64'(ifc.o_illegal), 64'd0);

    // Reset while two ops are in flight
    issue(7'o051, 3'd1, 3'd1, 64'd1, 64'd2, 64'd0, 3'd3);
    issue(7'o051, 3'd1, 3'd1, 64'd4, 64'd8, 64'd0, 3'd4);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (STAGES + 2) step();
    chk("rst_flush", 64'(ifc.o_valid), 64'd0);

    // Random traffic with holds, issues during hold, and occasional reset
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      ifc.i_hold = ($urandom_range(0, 99) < 15);
      ifc.i_valid = ($urandom_range(0, 99) < 75);
      ifc.i_instr = ops[$urandom_range(0, 11)];
      ifc.i_j = 3'($urandom_range(0, 7));
      ifc.i_k = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      ifc.i_sj = {$urandom, $urandom};
      ifc.i_sk = {$urandom, $urandom};
      ifc.i_si = {$urandom, $urandom};
      ifc.i_tag = TAG_W'($urandom);
      step();
    end
    rst = 0; ifc.i_hold = 0; ifc.i_valid = 0;
    repeat (STAGES + 1) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
